// File: rtl/button_dir_latch.sv
// button_dir_latch: synchronises and debounces the four push-buttons and turns
// debounced press events into a held 3-bit direction code for the CPU to poll.
module button_dir_latch #(
   parameter int unsigned DEBOUNCE_CYCLES = 290000,
   parameter int unsigned CNT_WIDTH       = 19,
   parameter bit          REJECT_REVERSE  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       BTNU,
   input  logic       BTNR,
   input  logic       BTND,
   input  logic       BTNL,
   input  logic       clear,
   output logic [2:0] button_reg,
   output logic       new_dir
);

   typedef enum logic [2:0] {
      DIR_NONE  = 3'd0,
      DIR_UP    = 3'd1,
      DIR_RIGHT = 3'd2,
      DIR_DOWN  = 3'd3,
      DIR_LEFT  = 3'd4
   } dir_e;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   // Button lanes: bit 0 up, 1 right, 2 down, 3 left (also the priority order).
   logic [3:0]           raw;
   logic [3:0]           sync1_q, sync1_d;
   logic [3:0]           sync2_q, sync2_d;
   logic [3:0]           stable_q, stable_d;
   logic [3:0]           stable_dly_q, stable_dly_d;
   logic [CNT_WIDTH-1:0] cnt_q [4];
   logic [CNT_WIDTH-1:0] cnt_d [4];
   logic [3:0]           press;
   dir_e                 evt_code;
   logic                 reverse;
   dir_e                 button_reg_q, button_reg_d;
   logic                 new_dir_q, new_dir_d;

   assign raw = {BTNL, BTND, BTNR, BTNU};

   // Two-flop synchroniser chain and one-cycle delay of the debounced state.
   always_comb begin
      sync1_d      = raw;
      sync2_d      = sync1_q;
      stable_dly_d = stable_q;
   end

   // Per-button debounce: flip stable only after DEBOUNCE_CYCLES disagreeing cycles.
   always_comb begin
      stable_d = stable_q;
      for (int unsigned i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Rising edges of the debounced levels, reduced to the single highest-priority code.
   always_comb begin
      press    = stable_q & ~stable_dly_q;
      evt_code = DIR_NONE;
      if (press[0])      evt_code = DIR_UP;
      else if (press[1]) evt_code = DIR_RIGHT;
      else if (press[2]) evt_code = DIR_DOWN;
      else if (press[3]) evt_code = DIR_LEFT;
   end

   // Direction register next state: clear, then hold on no/same/reversed event, else take it.
   always_comb begin
      button_reg_d = button_reg_q;
      new_dir_d    = 1'b0;
      reverse      = ((evt_code == DIR_UP)    && (button_reg_q == DIR_DOWN))  ||
                     ((evt_code == DIR_DOWN)  && (button_reg_q == DIR_UP))    ||
                     ((evt_code == DIR_RIGHT) && (button_reg_q == DIR_LEFT))  ||
                     ((evt_code == DIR_LEFT)  && (button_reg_q == DIR_RIGHT));
      if (clear) begin
         button_reg_d = DIR_NONE;
      end else if ((evt_code != DIR_NONE) && (evt_code != button_reg_q) &&
                   !(REJECT_REVERSE && reverse)) begin
         button_reg_d = evt_code;
         new_dir_d    = 1'b1;
      end
   end

   // State registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
         button_reg_q <= DIR_NONE;
         new_dir_q    <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         button_reg_q <= button_reg_d;
         new_dir_q    <= new_dir_d;
      end
   end

   assign button_reg = button_reg_q;
   assign new_dir    = new_dir_q;

endmodule

// File: doc/button_dir_latch.md
# button_dir_latch

Input-conditioning stage that sits directly upstream of the processor's memory-mapped button word at dmem address 0. It synchronises and debounces the four board push-buttons (BTNU/BTNR/BTND/BTNL) and turns debounced press events into a held 3-bit direction code. The code ignores immediate reversals. The processor polls the code each game tick. A synchronous `clear` returns the code to "none" on game restart.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 290000: consecutive cycles a synchronised input must differ from its debounced state before that state flips. This is about 10 ms at 29 MHz. Legal range is ≥ 2.
- `CNT_WIDTH`, default 19: width of each debounce counter. Must hold DEBOUNCE_CYCLES-1.
- `REJECT_REVERSE`, default 1: when 1, a press opposite to the current direction is discarded.

Ports:
- `clk`, in, 1: the single clock, the processor clock.
- `reset`, in, 1: asynchronous, active-high. Clears all state.
- `BTNU`, `BTNR`, `BTND`, `BTNL`, in, 1 each: raw, asynchronous button levels. 1 means pressed.
- `clear`, in, 1: synchronous. Forces `button_reg` to 0 on the next edge.
- `button_reg`, out, 3: held direction code. 0 none, 1 up, 2 right, 3 down, 4 left.
- `new_dir`, out, 1: one-cycle pulse on every edge where `button_reg` takes a new nonzero value.

## Operation

Synchroniser:
- Each raw button passes through 2 flops, sync1 then sync2. Reset value is 0.

Debounce, per button:
- Each button has a `stable` bit and a counter `cnt`. Both reset to 0.
- If sync2 == stable: cnt <= 0.
- Else, if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
- Else: cnt <= cnt+1.
- A pulse shorter than DEBOUNCE_CYCLES cycles never changes `stable`.

Press event:
- A press event for a button is `stable & ~stable_q`, where stable_q is `stable` delayed by one cycle.
- Releases produce no event.
- A held button produces exactly one event; there is no auto-repeat.

Priority:
- When several events fire in the same cycle, pick up > right > down > left.
- Only the winner is considered. The losers are dropped, not queued.

Direction register update. Evaluate the rules in order; the first one that applies decides the edge:
1. `clear`=1: button_reg <= 0. Any event in that cycle is dropped.
2. No event: hold.
3. Event code c == button_reg: hold. `new_dir` stays 0.
4. REJECT_REVERSE=1, button_reg ≠ 0, and c is the opposite of button_reg (1↔3, 2↔4): hold.
5. Otherwise: button_reg <= c and `new_dir` <= 1 for that one cycle.

Reset:
- Asserting `reset` mid-debounce zeroes all counters, `stable`, the synchronisers and the outputs.
- A button still held when reset releases is treated as a fresh press. It needs the full latency.
- Values 5–7 on `button_reg` are unreachable.

## Timing

- All flops are on `posedge clk`. Reset is asynchronous assert, released synchronously by the system.
- Reset values: `button_reg`=0, `new_dir`=0.
- Latency is counted from the first edge that samples a raw 1 as edge 1:
  - sync1 at edge 1, sync2 at edge 2.
  - counting on edges 3…D+2; `stable` flips on edge D+2.
  - `button_reg`/`new_dir` update on edge D+3. D = DEBOUNCE_CYCLES.
- Release is debounced with the same latency but has no output effect. A re-press is accepted only after the release has been debounced.
- `clear` has one-edge latency. `new_dir` is never 1 in a cycle following a `clear` edge unless a new, later event occurs.
- `button_reg` is stable between update edges, so combinational reads from the dmem mux are safe.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

1. Reset, then hold BTNU high for 12 cycles → `button_reg` goes 0→1 on edge 7. `new_dir` is high for exactly the cycle after edge 7. There is no second pulse while the button is held.
2. From `button_reg`=1, BTNR glitches high for 3 cycles then low → `button_reg` stays 1 and `new_dir` never pulses. Then hold BTNR for 6 cycles → `button_reg`=2 on edge 7.
3. From `button_reg`=2, press BTNL and hold → stays 2 (reverse rejected). Release, debounce, then press BTND → becomes 3 with one `new_dir` pulse. Repeat with REJECT_REVERSE=0: BTNL from 2 → 4.
4. From `button_reg`=0, raise BTNU and BTNL on the same edge → `button_reg`=1. Keep BTNL held → no later change to 4, because its event was already consumed.
5. From `button_reg`=3, assert `clear` on the exact edge where a BTNR event fires → `button_reg`=0 and `new_dir`=0. Pressing BTNR again later → 2.
6. Hold BTND, assert `reset` for 1 cycle at cnt=2, then release reset → outputs 0 immediately. `button_reg`=3 exactly D+3 edges after reset release, proving the counter restarted.
